// File: rtl/uart_mem_dump_pkg.sv
// Definitions shared by the UART memory dump and the serial loader:
// FSM encoding, UART frame constants and the record address-byte format.
package uart_mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_A,
    WAIT_A,
    SEND_D,
    WAIT_D,
    FINISH
  } dumpState_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;
  localparam int   BYTE_W     = 8;

  // Address byte of a record: the address zero-extended, upper bits forced clear.
  function automatic logic [BYTE_W-1:0] recordAddrByte(input logic [BYTE_W-1:0] addr,
                                                       input int addrW);
    logic [BYTE_W-1:0] mask;
    mask = BYTE_W'((1 << addrW) - 1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/uart_mem_dump_tx_core.sv
// UART bit serializer: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each bit held for CLKS_PER_BIT clocks.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);
  import uart_mem_dump_pkg::*;

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      r_ClkCnt;
  logic [3:0]            r_BitIdx;
  logic [FRAME_BITS-1:0] r_Shift;
  logic                  r_Active;
  logic                  w_BitEnd;

  assign w_BitEnd = (r_ClkCnt == CNT_LAST);

  // The whole frame is loaded at once and shifted out from bit 0 at each bit boundary.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_Active <= 1'b0;
      r_ClkCnt <= '0;
      r_BitIdx <= '0;
      r_Shift  <= '1;
    end else if (!r_Active) begin
      r_ClkCnt <= '0;
      r_BitIdx <= '0;
      if (i_TX_DV) begin
        r_Active <= 1'b1;
        r_Shift  <= {STOP_BIT, i_TX_Byte, START_BIT};
      end
    end else if (w_BitEnd) begin
      r_ClkCnt <= '0;
      r_Shift  <= {STOP_BIT, r_Shift[FRAME_BITS-1:1]};
      if (r_BitIdx == BIT_LAST) begin
        r_Active <= 1'b0;
      end else begin
        r_BitIdx <= r_BitIdx + 4'd1;
      end
    end else begin
      r_ClkCnt <= r_ClkCnt + CNT_W'(1);
    end
  end

  assign o_TX_Serial = r_Active ? r_Shift[0] : 1'b1;
  assign o_TX_Active = r_Active;
  assign o_TX_Done   = r_Active && w_BitEnd && (r_BitIdx == BIT_LAST);

endmodule

// File: rtl/uart_mem_dump.sv
// Memory dump transmitter: reads every RAM word in address order and sends
// each as an {address byte, value byte} record in the serial loader's format.
module uart_mem_dump #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic [DATA_W-1:0] i_Mem_Data,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_TX_Serial,
  output logic              o_TX_Active
);
  import uart_mem_dump_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  dumpState_t        r_State;
  dumpState_t        w_Next;
  logic [ADDR_W-1:0] r_Addr;
  logic [DATA_W-1:0] r_Data;
  logic              w_TxDv;
  logic [7:0]        w_TxByte;
  logic              w_TxDone;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_Next;
    end
  end

  always_comb begin
    w_Next   = r_State;
    w_TxDv   = 1'b0;
    w_TxByte = r_Data;
    o_Busy   = 1'b1;
    o_Done   = 1'b0;
    case (r_State)
      IDLE: begin
        o_Busy = 1'b0;
        if (i_Start) w_Next = FETCH;
      end
      FETCH:  w_Next = LATCH;
      LATCH:  w_Next = SEND_A;
      SEND_A: begin
        w_TxDv   = 1'b1;
        w_TxByte = recordAddrByte(8'(r_Addr), ADDR_W);
        w_Next   = WAIT_A;
      end
      WAIT_A: if (w_TxDone) w_Next = SEND_D;
      SEND_D: begin
        w_TxDv = 1'b1;
        w_Next = WAIT_D;
      end
      WAIT_D: begin
        if (w_TxDone) w_Next = (r_Addr == ADDR_LAST) ? FINISH : FETCH;
      end
      FINISH: begin
        o_Busy = 1'b0;
        o_Done = 1'b1;
        w_Next = IDLE;
      end
      default: w_Next = IDLE;
    endcase
  end

  // The last-address test precedes the increment, so the counter never wraps mid-dump.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_Addr <= '0;
      r_Data <= '0;
    end else begin
      if (r_State == IDLE && i_Start) r_Addr <= '0;
      if (r_State == LATCH) r_Data <= i_Mem_Data;
      if (r_State == WAIT_D && w_TxDone && r_Addr != ADDR_LAST) begin
        r_Addr <= r_Addr + ADDR_W'(1);
      end
    end
  end

  assign o_Mem_Addr = r_Addr;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_TxCore (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_TX_DV    (w_TxDv),
    .i_TX_Byte  (w_TxByte),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Active(o_TX_Active),
    .o_TX_Done  (w_TxDone)
  );

endmodule
